td4_prog_loader: RTL and testbench
==================================

Name: td4_prog_loader

Overview:
- Serial program loader that writes the TD4 program memory the CPU core fetches from.
- Receives an 8N1 UART frame stream and writes each payload byte to consecutive memory addresses.
- Holds the CPU in reset while loading and releases it only after a good checksum.
- Sits between the board serial pin and the program memory write port, beside the td4 core.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (>=4); the mid-bit sample is taken at CLK_DIV/2.
- ADDR_W, 4, program memory address width; payload length is 2**ADDR_W bytes.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rxd  input  1  UART receive line, idle high, asynchronous to clk.
- wr_en  output  1  program memory write strobe, one-cycle pulse.
- wr_addr  output  ADDR_W  program memory write address.
- wr_data  output  8  program memory write data: op[7:4], im[3:0].
- cpu_rst  output  1  held high while the CPU must not run.
- busy  output  1  high while a frame is in progress (state LOAD or CHECK).
- done  output  1  high in state RUN.
- err  output  1  sticky; set on checksum, framing or parity error; cleared by the next SYNC.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, busy=0, done=0, err=0. FSM=WAIT_SYNC. Receiver idle.
- Input sync: rxd passes through a 2-FF synchronizer before any use. Its reset value is 1.
- Receiver, start detect: a 1->0 transition on synced rxd starts a bit counter.
- Receiver, start check: sample at CLK_DIV/2. If the sample is 1, treat it as a glitch and return to idle with no byte and no error.
- Receiver, data: 8 data bits LSB first, each sampled CLK_DIV cycles after the previous sample.
- Receiver, stop: the stop bit is sampled. If it is 0, this is a framing error: no byte is delivered, err is set, and FSM goes to FAIL.
- Receiver, byte valid: asserts for 1 cycle on the stop-bit sample cycle. The receiver rearms immediately and can detect a new start edge in the next cycle.
- FSM WAIT_SYNC: byte==SYNC -> LOAD, with addr counter=0, sum=0, err cleared. Any other byte is ignored.
- FSM LOAD: on each byte:
  - wr_en pulses 1 cycle after byte valid, with wr_addr=counter and wr_data=byte.
  - sum += byte (mod 256), then counter increments.
  - After byte 2**ADDR_W-1 is written -> CHECK. The counter does not wrap into extra writes.
- FSM CHECK: the next byte is the checksum.
  - (sum + byte) mod 256 == 0 -> RUN.
  - Otherwise -> FAIL with err=1.
  - No memory write occurs for the checksum byte.
- FSM RUN: cpu_rst=0 and done=1, starting from the cycle after the transition. A SYNC byte -> LOAD.
- FSM FAIL: cpu_rst=1, done=0, err held. A SYNC byte -> LOAD.
- Re-entry from RUN or FAIL: cpu_rst rises the cycle after the SYNC byte valid, before the first write.
- cpu_rst is 1 in every state except RUN.
- In LOAD or CHECK a SYNC value is treated as ordinary data; there is no resync mid-frame.
- Reset mid-frame: all state returns to reset values immediately, even if wr_en is asserted.
  - Already-written memory contents are not cleared.
  - The CPU stays in reset until a complete good frame arrives.
- Only wr_en qualifies wr_addr and wr_data. Both hold their last value otherwise.

Optional Feature:
- Macro: TD4_LOADER_PARITY_EN.
- Defined: the frame is 8E1. An even-parity bit follows data bit 7 and is sampled like a data bit.
  - A parity mismatch is treated exactly as a framing error: byte dropped, err=1, FSM -> FAIL.
- Not defined: plain 8N1, with no parity logic present.

Test Plan:
- Reset: rst=1 then 0 with rxd=1 -> cpu_rst=1, done=0, err=0, no wr_en for 1000 cycles.
- Good load (CLK_DIV=8, ADDR_W=4): send A5, then 00..0F (sum 0x78), then 0x88 ->
  - 16 wr_en pulses with wr_addr=0..15 and wr_data=0x00..0x0F.
  - done=1 and cpu_rst=0 after the checksum byte.
- Bad checksum: same frame ending 0x89 -> 16 writes, then err=1, cpu_rst=1, done=0.
  - A following good frame clears err and ends with done=1.
- Noise: send 3C, 5A before A5 -> no writes until A5. A 2-cycle low glitch on rxd produces no byte.
- Reload: in RUN send A5 -> cpu_rst=1 the cycle after the byte. Send stop bit=0 on byte 3 -> err=1, FSM in FAIL, only 2 writes done.
- Mid-frame reset: assert rst after 5 payload bytes -> outputs return to reset values asynchronously. A new full frame then loads correctly from addr 0.

Source files
------------

// File: rtl/td4_prog_loader_if.sv
// Program memory write port shared between the serial loader (master) and the
// TD4 program memory (slave).
interface td4_prog_loader_if #(
   parameter int unsigned ADDR_W = 4
) ();
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data
   );

   modport slave (
      input wr_en,
      input wr_addr,
      input wr_data
   );
endinterface

// File: rtl/td4_prog_loader.sv
// Serial program loader for the TD4 core. Receives a UART frame
// (SYNC, 2**ADDR_W payload bytes, checksum), writes the payload to program
// memory and releases the CPU from reset only after a good checksum.
// Optional: define TD4_LOADER_PARITY_EN for 8E1 framing (default 8N1).
module td4_prog_loader #(
   parameter int unsigned CLK_DIV = 434,
   parameter int unsigned ADDR_W  = 4,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rxd,
   td4_prog_loader_if.master   wr,
   output logic                cpu_rst,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int unsigned CntW = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      RxIdle,
      RxStart,
      RxData,
`ifdef TD4_LOADER_PARITY_EN
      RxParity,
`endif
      RxStop
   } rx_state_e;

   typedef enum logic [2:0] {
      StWaitSync,
      StLoad,
      StCheck,
      StRun,
      StFail
   } ld_state_e;

   logic            sync1_q, sync2_q, rxd_prev_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            rx_valid, rx_err;

   ld_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]      sum_q, sum_d;
   logic            err_q, err_d;
   logic            wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic [7:0]      byte_sum;

   // Two-flop synchronizer plus one delayed copy for start-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync1_q    <= rxd;
         sync2_q    <= sync1_q;
         rxd_prev_q <= sync2_q;
      end
   end

   // Receiver state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= RxIdle;
         cnt_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
      end
   end

   // Receiver: start check at mid-bit, then one sample every CLK_DIV cycles.
   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      rx_valid   = 1'b0;
      rx_err     = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            cnt_d = '0;
            if (rxd_prev_q && !sync2_q) rx_state_d = RxStart;
         end
         RxStart: begin
            if (cnt_q == CntHalf) begin
               cnt_d      = '0;
               bit_d      = '0;
               // A high sample here is a glitch: silently rearm.
               rx_state_d = sync2_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (cnt_q == CntFull) begin
               cnt_d   = '0;
               shreg_d = {sync2_q, shreg_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
`ifdef TD4_LOADER_PARITY_EN
                  rx_state_d = RxParity;
`else
                  rx_state_d = RxStop;
`endif
               end
            end
         end
`ifdef TD4_LOADER_PARITY_EN
         RxParity: begin
            if (cnt_q == CntFull) begin
               cnt_d = '0;
               if (sync2_q != ^shreg_q) begin
                  rx_err     = 1'b1;
                  rx_state_d = RxIdle;
               end else begin
                  rx_state_d = RxStop;
               end
            end
         end
`endif
         RxStop: begin
            if (cnt_q == CntFull) begin
               rx_state_d = RxIdle;
               rx_valid   = sync2_q;
               rx_err     = !sync2_q;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   assign byte_sum = sum_q + shreg_q;

   // Loader FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StWaitSync;
      else     state_q <= state_d;
   end

   // Loader FSM next state.
   always_comb begin
      state_d = state_q;
      if (rx_err) begin
         state_d = StFail;
      end else if (rx_valid) begin
         unique case (state_q)
            StWaitSync, StRun, StFail: if (shreg_q == SYNC) state_d = StLoad;
            StLoad:  if (addr_q == '1) state_d = StCheck;
            StCheck: state_d = (byte_sum == 8'h00) ? StRun : StFail;
            default: state_d = StWaitSync;
         endcase
      end
   end

   // Loader FSM outputs; CPU only runs after a verified frame.
   always_comb begin
      cpu_rst = (state_q != StRun);
      done    = (state_q == StRun);
      busy    = (state_q == StLoad) || (state_q == StCheck);
   end

   // Datapath registers: address counter, running sum, sticky error, write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         sum_q     <= '0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         addr_q    <= addr_d;
         sum_q     <= sum_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Datapath next state; addr/data hold their last value between writes.
   always_comb begin
      addr_d    = addr_q;
      sum_d     = sum_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (rx_err) begin
         err_d = 1'b1;
      end else if (rx_valid) begin
         unique case (state_q)
            StWaitSync, StRun, StFail: begin
               if (shreg_q == SYNC) begin
                  addr_d = '0;
                  sum_d  = '0;
                  err_d  = 1'b0;
               end
            end
            StLoad: begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = shreg_q;
               sum_d     = byte_sum;
               addr_d    = addr_q + 1'b1;
            end
            StCheck: if (byte_sum != 8'h00) err_d = 1'b1;
            default: ;
         endcase
      end
   end

   assign wr.wr_en   = wr_en_q;
   assign wr.wr_addr = wr_addr_q;
   assign wr.wr_data = wr_data_q;
   assign err        = err_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader: a scoreboard of expected memory
// writes is filled as bytes are sent and drained against observed writes.
module tb_td4_prog_loader;

   localparam int unsigned CLK_DIV = 8;
   localparam int unsigned ADDR_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic cpu_rst, busy, done, err;

   int total = 0;
   int bad   = 0;

   logic [11:0] exp_q[$];
   logic [11:0] got_q[$];

   td4_prog_loader_if #(.ADDR_W(ADDR_W)) wr_if ();

   td4_prog_loader #(
      .CLK_DIV (CLK_DIV),
      .ADDR_W  (ADDR_W),
      .SYNC    (8'hA5)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rxd     (rxd),
      .wr      (wr_if.master),
      .cpu_rst (cpu_rst),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Capture every write strobe away from the active edge.
   always @(negedge clk) begin
      if (wr_if.wr_en) got_q.push_back({wr_if.wr_addr, wr_if.wr_data});
   end

   // Drive one UART frame, then reconcile observed writes with the scoreboard.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [11:0] g, e;
      @(negedge clk);
      rxd = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
`ifdef TD4_LOADER_PARITY_EN
      rxd = ^b;
      repeat (CLK_DIV) @(negedge clk);
`endif
      rxd = stop_bit;
      repeat (CLK_DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got addr/data=%h required none", g);
         end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
               bad++;
               $display("FAIL write got addr/data=%h required %h", g, e);
            end
         end
      end
   endtask

   task automatic send_payload(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({4'(i), 8'(i)});
         send_byte(8'(i), 1'b1);
      end
   endtask

   task automatic send_frame(input logic [7:0] ck);
      send_byte(8'hA5, 1'b1);
      send_payload(16);
      send_byte(ck, 1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({cpu_rst, done, err, busy, wr_if.wr_en} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_outputs got %b required 10000", {cpu_rst, done, err, busy, wr_if.wr_en});
      end
      repeat (1000) @(negedge clk);
      total++;
      if ({cpu_rst, done, err, got_q.size() == 0} !== 4'b1001) begin
         bad++;
         $display("FAIL reset_idle got %b required 1001", {cpu_rst, done, err, got_q.size() == 0});
      end
   endtask

   task automatic test_noise;
      send_byte(8'h3C, 1'b1);
      send_byte(8'h5A, 1'b1);
      @(negedge clk);
      rxd = 1'b0;
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      total++;
      if ({busy, err, got_q.size() == 0} !== 3'b001) begin
         bad++;
         $display("FAIL noise_ignored got %b required 001", {busy, err, got_q.size() == 0});
      end
      send_byte(8'hA5, 1'b1);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL sync_accept busy got %b required 1", busy);
      end
      send_payload(16);
      send_byte(8'h88, 1'b1);
      total++;
      if ({done, cpu_rst, err} !== 3'b100) begin
         bad++;
         $display("FAIL noise_then_load got %b required 100", {done, cpu_rst, err});
      end
   endtask

   task automatic test_good_load;
      send_frame(8'h88);
      total++;
      if ({done, cpu_rst, err, busy} !== 4'b1000) begin
         bad++;
         $display("FAIL good_load got %b required 1000", {done, cpu_rst, err, busy});
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL good_load_writes pending got %0d required 0", exp_q.size());
      end
   endtask

   task automatic test_bad_checksum;
      send_frame(8'h89);
      total++;
      if ({done, cpu_rst, err, busy} !== 4'b0110) begin
         bad++;
         $display("FAIL bad_checksum got %b required 0110", {done, cpu_rst, err, busy});
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL bad_checksum_writes pending got %0d required 0", exp_q.size());
      end
      send_byte(8'hA5, 1'b1);
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL sync_clears_err got %b required 0", err);
      end
      send_payload(16);
      send_byte(8'h88, 1'b1);
      total++;
      if ({done, cpu_rst, err} !== 3'b100) begin
         bad++;
         $display("FAIL recover_load got %b required 100", {done, cpu_rst, err});
      end
   endtask

   task automatic test_reload;
      total++;
      if (cpu_rst !== 1'b0) begin
         bad++;
         $display("FAIL reload_pre cpu_rst got %b required 0", cpu_rst);
      end
      send_byte(8'hA5, 1'b1);
      total++;
      if ({cpu_rst, done, busy} !== 3'b101) begin
         bad++;
         $display("FAIL reload_sync got %b required 101", {cpu_rst, done, busy});
      end
      send_payload(2);
      send_byte(8'h22, 1'b0);
      total++;
      if ({err, cpu_rst, done, busy} !== 4'b1100) begin
         bad++;
         $display("FAIL framing_err got %b required 1100", {err, cpu_rst, done, busy});
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL framing_writes pending got %0d required 0", exp_q.size());
      end
   endtask

   task automatic test_mid_reset;
      send_byte(8'hA5, 1'b1);
      send_payload(5);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if ({wr_if.wr_en, cpu_rst, busy, done, err} !== 5'b01000) begin
         bad++;
         $display("FAIL mid_reset_flags got %b required 01000", {wr_if.wr_en, cpu_rst, busy, done, err});
      end
      total++;
      if ({wr_if.wr_addr, wr_if.wr_data} !== 12'h000) begin
         bad++;
         $display("FAIL mid_reset_bus got %h required 000", {wr_if.wr_addr, wr_if.wr_data});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send_frame(8'h88);
      total++;
      if ({done, cpu_rst, err, exp_q.size() == 0} !== 4'b1001) begin
         bad++;
         $display("FAIL after_reset_load got %b required 1001", {done, cpu_rst, err, exp_q.size() == 0});
      end
   endtask

   initial begin
      test_reset;
      test_noise;
      test_good_load;
      test_bad_checksum;
      test_reload;
      test_mid_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
